// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/sequencing engine: opcodes, flow-control
// encodings, FSM states and instruction field positions.
package cpu_pkg;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_INSTR_W = 16;
   localparam int DEF_DATA_W  = 16;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_AND    = 4'h2;
   localparam logic [3:0] OP_OR     = 4'h3;
   localparam logic [3:0] OP_XOR    = 4'h4;
   localparam logic [3:0] OP_SLT    = 4'h5;
   localparam logic [3:0] OP_ADDI   = 4'h6;
   localparam logic [3:0] OP_LW     = 4'h7;
   localparam logic [3:0] OP_SW     = 4'h8;
   localparam logic [3:0] OP_BEQ    = 4'h9;
   localparam logic [3:0] OP_JI     = 4'hA;
   localparam logic [3:0] OP_JR     = 4'hB;
   localparam logic [3:0] OP_WR7SEG = 4'hC;
   localparam logic [3:0] OP_WRLEDS = 4'hD;
   localparam logic [3:0] OP_RDSW   = 4'hE;

   localparam logic [1:0] JIJR_NONE = 2'b00;
   localparam logic [1:0] JIJR_JR   = 2'b01;
   localparam logic [1:0] JIJR_JI   = 2'b10;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS_MSB  = 7;
   localparam int RS_LSB  = 4;
   localparam int OFF_MSB = 3;
   localparam int OFF_LSB = 0;
   localparam int JI_MSB  = 7;
   localparam int JI_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXEC    = 3'd3,
      ST_IO_WAIT = 3'd4
   } state_t;

   function automatic logic [15:0] sext4(input logic [3:0] v);
      return {{12{v[3]}}, v};
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of ROM, decoder and peripheral signals around the fetch sequencer.
interface fetch_sequencer_if
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int DATA_W  = DEF_DATA_W
);
   logic               run_i;
   logic [ADDR_W-1:0]  imem_addr_o;
   logic [INSTR_W-1:0] imem_data_i;
   logic [INSTR_W-1:0] instr_o;
   logic [3:0]         opcode_o;
   logic               beq_i;
   logic [1:0]         jijr_i;
   logic               regwrite_i;
   logic               wr7seg_i;
   logic               wrleds_i;
   logic               zero_i;
   logic [DATA_W-1:0]  rs_data_i;
   logic               io_busy_i;
   logic               regwrite_o;
   logic               wr7seg_o;
   logic               wrleds_o;
   logic [ADDR_W-1:0]  pc_o;
   logic [2:0]         state_o;

   modport master (
      input  run_i, imem_data_i, beq_i, jijr_i, regwrite_i, wr7seg_i, wrleds_i,
             zero_i, rs_data_i, io_busy_i,
      output imem_addr_o, instr_o, opcode_o, regwrite_o, wr7seg_o, wrleds_o,
             pc_o, state_o
   );

   modport slave (
      output run_i, imem_data_i, beq_i, jijr_i, regwrite_i, wr7seg_i, wrleds_i,
             zero_i, rs_data_i, io_busy_i,
      input  imem_addr_o, instr_o, opcode_o, regwrite_o, wr7seg_o, wrleds_o,
             pc_o, state_o
   );
endinterface

// File: rtl/fetch_sequencer_next_pc.sv
// Combinational next-PC selection: Ji over Jr over taken BEQ over sequential.
module next_pc_calc
   import cpu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [7:0]        instr_lo,
   input  logic              beq,
   input  logic [1:0]        jijr,
   input  logic              zero,
   input  logic [ADDR_W-1:0] rs_data,
   output logic [ADDR_W-1:0] next_pc
);
   logic [ADDR_W-1:0] pc_inc_s;
   logic [15:0]       off_ext_s;

   assign pc_inc_s  = pc + ADDR_W'(1);
   assign off_ext_s = sext4(instr_lo[OFF_MSB:OFF_LSB]);

   // Lower-priority inputs may be x from the decoder, so they are only looked at when reached
   always_comb begin
      next_pc = pc_inc_s;
      if (jijr[1]) begin
         next_pc = ADDR_W'(instr_lo[JI_MSB:JI_LSB]);
      end else if (jijr[0]) begin
         next_pc = rs_data;
      end else if (beq && zero) begin
         next_pc = pc_inc_s + off_ext_s[ADDR_W-1:0];
      end else begin
         next_pc = pc_inc_s;
      end
   end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer: drives ROM address, holds IR, applies next-PC
// and turns decoder levels into one-cycle write strobes, stalling on busy I/O.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input logic                clk,
   input logic                rst_n,
   fetch_sequencer_if.master  bus
);
   state_t             state_r;
   logic [ADDR_W-1:0]  pc_r;
   logic [INSTR_W-1:0] ir_r;
   logic [ADDR_W-1:0]  next_pc_s;
   logic               io_req_s;
   logic               commit_s;

   next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
      .pc       (pc_r),
      .instr_lo (ir_r[7:0]),
      .beq      (bus.beq_i),
      .jijr     (bus.jijr_i),
      .zero     (bus.zero_i),
      .rs_data  (bus.rs_data_i[ADDR_W-1:0]),
      .next_pc  (next_pc_s)
   );

   assign io_req_s = bus.wr7seg_i | bus.wrleds_i;

   // The instruction retires in EXEC unless it needs the busy peripheral, else when busy drops
   always_comb begin
      commit_s = 1'b0;
      case (state_r)
         ST_EXEC:    commit_s = ~(io_req_s & bus.io_busy_i);
         ST_IO_WAIT: commit_s = ~bus.io_busy_i;
         default:    commit_s = 1'b0;
      endcase
   end

   // Sequencer FSM with PC and instruction register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         pc_r    <= {ADDR_W{1'b0}};
         ir_r    <= {INSTR_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.run_i) state_r <= ST_FETCH;
               else           state_r <= ST_IDLE;
            end
            ST_FETCH: state_r <= ST_DECODE;
            ST_DECODE: begin
               ir_r    <= bus.imem_data_i;
               state_r <= ST_EXEC;
            end
            ST_EXEC, ST_IO_WAIT: begin
               if (commit_s) begin
                  pc_r    <= next_pc_s;
                  state_r <= bus.run_i ? ST_FETCH : ST_IDLE;
               end else begin
                  state_r <= ST_IO_WAIT;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign bus.imem_addr_o = pc_r;
   assign bus.pc_o        = pc_r;
   assign bus.instr_o     = ir_r;
   assign bus.opcode_o    = ir_r[OPC_MSB:OPC_LSB];
   assign bus.state_o     = state_r;
   assign bus.regwrite_o  = (state_r == ST_EXEC) & bus.regwrite_i;
   assign bus.wr7seg_o    = commit_s & bus.wr7seg_i;
   assign bus.wrleds_o    = commit_s & bus.wrleds_i;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: the bench plays ROM and decoder and walks a short program.
module tb_fetch_sequencer;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] rom [0:255];

   always #5 clk = ~clk;

   fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(16), .DATA_W(16)) ifc ();

   fetch_sequencer #(.ADDR_W(8), .INSTR_W(16), .DATA_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.master)
   );

   // Synchronous ROM, one-cycle read latency
   always @(posedge clk) ifc.imem_data_i <= rom[ifc.imem_addr_o];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_dec(input logic rw, input logic [1:0] jj, input logic b, input logic z,
                          input logic w7, input logic wl, input logic [15:0] rs);
      ifc.regwrite_i = rw;
      ifc.jijr_i     = jj;
      ifc.beq_i      = b;
      ifc.zero_i     = z;
      ifc.wr7seg_i   = w7;
      ifc.wrleds_i   = wl;
      ifc.rs_data_i  = rs;
   endtask

   // Entered in FETCH; runs DECODE and EXEC and checks the retired PC
   task automatic run_instr(input string tag, input logic [15:0] ir, input logic rw,
                            input logic [7:0] pc_exp);
      tick();
      chk({tag, "_decode_state"}, ifc.state_o, ST_DECODE);
      chk({tag, "_decode_rw"}, ifc.regwrite_o, 1'b0);
      tick();
      chk({tag, "_exec_ir"}, ifc.instr_o, ir);
      chk({tag, "_exec_opcode"}, ifc.opcode_o, ir[15:12]);
      chk({tag, "_exec_rw"}, ifc.regwrite_o, rw);
      tick();
      chk({tag, "_pc"}, ifc.pc_o, pc_exp);
      chk({tag, "_fetch_state"}, ifc.state_o, ST_FETCH);
      chk({tag, "_fetch_addr"}, ifc.imem_addr_o, pc_exp);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      rom[8'h00] = 16'h0123;
      rom[8'h01] = 16'hA010;
      rom[8'h10] = 16'h912E;
      rom[8'h0F] = 16'hA010;
      rom[8'h11] = 16'hA040;
      rom[8'h40] = 16'hB500;
      rom[8'h34] = 16'hA0FC;
      rom[8'hFC] = 16'h9127;
      rom[8'h04] = 16'hC100;
      rom[8'h05] = 16'hA0FF;
      rom[8'hFF] = 16'h0456;

      rst_n         = 1'b0;
      ifc.run_i     = 1'b0;
      ifc.io_busy_i = 1'b0;
      set_dec(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      tick();
      chk("rst_state", ifc.state_o, ST_IDLE);
      chk("rst_pc", ifc.pc_o, 8'h00);
      chk("rst_addr", ifc.imem_addr_o, 8'h00);
      chk("rst_ir", ifc.instr_o, 16'h0000);
      chk("rst_rw", ifc.regwrite_o, 1'b0);
      chk("rst_7seg", ifc.wr7seg_o, 1'b0);
      chk("rst_leds", ifc.wrleds_o, 1'b0);

      rst_n = 1'b1;
      tick();
      chk("idle_hold", ifc.state_o, ST_IDLE);
      ifc.run_i = 1'b1;
      tick();
      chk("first_fetch", ifc.state_o, ST_FETCH);
      chk("first_addr", ifc.imem_addr_o, 8'h00);
      run_instr("add", 16'h0123, 1'b1, 8'h01);

      set_dec(1'b0, 2'b10, 1'bx, 1'b0, 1'b0, 1'b0, 16'h0000);
      run_instr("ji10", 16'hA010, 1'b0, 8'h10);
      set_dec(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      run_instr("beq_taken", 16'h912E, 1'b0, 8'h0F);
      set_dec(1'b0, 2'b10, 1'bx, 1'b0, 1'b0, 1'b0, 16'h0000);
      run_instr("ji10_again", 16'hA010, 1'b0, 8'h10);
      set_dec(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      run_instr("beq_not_taken", 16'h912E, 1'b0, 8'h11);
      set_dec(1'b0, 2'b10, 1'bx, 1'bx, 1'b0, 1'b0, 16'hxxxx);
      run_instr("ji40", 16'hA040, 1'b0, 8'h40);
      set_dec(1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234);
      run_instr("jr", 16'hB500, 1'b0, 8'h34);
      set_dec(1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00AA);
      run_instr("jijr11", 16'hA0FC, 1'b0, 8'hFC);
      set_dec(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      run_instr("beq_wrap", 16'h9127, 1'b0, 8'h04);

      // Write7Seg with the peripheral busy for five cycles
      set_dec(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      ifc.io_busy_i = 1'b1;
      tick();
      chk("io_decode", ifc.state_o, ST_DECODE);
      tick();
      chk("io_exec_state", ifc.state_o, ST_EXEC);
      chk("io_exec_strobe", ifc.wr7seg_o, 1'b0);
      tick();
      chk("io_wait_state", ifc.state_o, ST_IO_WAIT);
      chk("io_wait_strobe", ifc.wr7seg_o, 1'b0);
      chk("io_wait_pc", ifc.pc_o, 8'h04);
      ifc.run_i = 1'b0;
      tick();
      chk("io_wait_runlow", ifc.state_o, ST_IO_WAIT);
      chk("io_wait_strobe2", ifc.wr7seg_o, 1'b0);
      tick();
      tick();
      chk("io_wait_pc_held", ifc.pc_o, 8'h04);
      chk("io_wait_strobe4", ifc.wr7seg_o, 1'b0);
      tick();
      ifc.io_busy_i = 1'b0;
      #1;
      chk("io_release_strobe", ifc.wr7seg_o, 1'b1);
      chk("io_release_leds", ifc.wrleds_o, 1'b0);
      chk("io_release_pc", ifc.pc_o, 8'h04);
      tick();
      chk("io_done_state", ifc.state_o, ST_IDLE);
      chk("io_done_strobe", ifc.wr7seg_o, 1'b0);
      chk("io_done_pc", ifc.pc_o, 8'h05);

      set_dec(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      ifc.run_i = 1'b1;
      tick();
      chk("resume_addr", ifc.imem_addr_o, 8'h05);
      run_instr("ji_ff", 16'hA0FF, 1'b0, 8'hFF);

      // Sequential wrap at 0xFF with run dropped during EXEC
      set_dec(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      tick();
      tick();
      chk("wrap_exec_rw", ifc.regwrite_o, 1'b1);
      ifc.run_i = 1'b0;
      tick();
      chk("halt_state", ifc.state_o, ST_IDLE);
      chk("wrap_pc", ifc.pc_o, 8'h00);
      tick();
      tick();
      chk("halt_hold_state", ifc.state_o, ST_IDLE);
      chk("halt_hold_pc", ifc.pc_o, 8'h00);
      chk("halt_hold_rw", ifc.regwrite_o, 1'b0);

      ifc.run_i = 1'b1;
      tick();
      run_instr("add_again", 16'h0123, 1'b1, 8'h01);
      tick();
      chk("pre_rst_state", ifc.state_o, ST_DECODE);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_state", ifc.state_o, ST_IDLE);
      chk("midrst_pc", ifc.pc_o, 8'h00);
      chk("midrst_ir", ifc.instr_o, 16'h0000);
      chk("midrst_opcode", ifc.opcode_o, 4'h0);
      chk("midrst_rw", ifc.regwrite_o, 1'b0);
      tick();
      chk("midrst_hold_state", ifc.state_o, ST_IDLE);
      chk("midrst_hold_rw", ifc.regwrite_o, 1'b0);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
